sseg_scan_mux: RTL and testbench
================================

Name: sseg_scan_mux

Overview:
- Time-multiplexes four registered 7-segment patterns onto one shared segment bus and four digit-enable lines. This suits the EP4CE10 board's common-segment 4-digit display.
- Sits downstream of the bin_to_sseg decoders: it reads the hex3..hex0 buses and drives the physical pins.
- Includes a per-digit ghosting guard (blanking interval) and a frame strobe for downstream logic.

Parameters:
- DIGIT_CYCLES, 50000, clock cycles per digit slot (1 ms at 50 MHz; 250 Hz frame). Must be >= 2.
- BLANK_CYCLES, 500, cycles at the start of each slot with all digits off. Must satisfy 0 <= BLANK_CYCLES < DIGIT_CYCLES.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  display enable; 0 forces digits off while the scan keeps running
- blank_mask  in  4  bit i=1 forces digit i off
- hex3, hex2, hex1, hex0  in  8 each  active-low segment patterns, bit7 = dp, bits6:0 = g..a
- an  out  4  digit enables, active-low, an[i] drives digit i
- sseg  out  8  shared segment bus, active-low
- frame_tick  out  1  one-cycle pulse at the end of each full 4-digit frame

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous, active-low (rst_n).
- Reset values: cnt=0, idx=0, an=4'b1111, sseg=8'hFF, frame_tick=0. Reset mid-slot aborts the slot immediately; the scan restarts at digit 0, cnt 0.
- Slot counter: cnt counts 0..DIGIT_CYCLES-1 each cycle, width $clog2(DIGIT_CYCLES). When cnt==DIGIT_CYCLES-1, cnt wraps to 0 and idx increments mod 4 (3->0).
- Latch: when cnt==0, pat_q <= hex[idx]. Input changes mid-slot are ignored until that digit's next slot.
- Phases:
  - BLANK: cnt < BLANK_CYCLES; an=4'b1111, sseg=8'hFF.
  - SHOW: cnt >= BLANK_CYCLES; an = ~(4'b0001<<idx), sseg=pat_q.
  - With BLANK_CYCLES=0, SHOW runs for the whole slot.
- Output registration: an and sseg are registered, so pins reflect the cnt/idx phase with 1-cycle latency. First SHOW cycle on pins = cycle after cnt==BLANK_CYCLES (cnt==0 when BLANK_CYCLES=0).
- Forced off: if en=0 or blank_mask[idx]=1, SHOW outputs an=4'b1111, sseg=8'hFF. Evaluated every cycle, so mid-slot changes take effect after 1 cycle.
- frame_tick: registered; high for exactly one cycle, the cycle after idx wraps 3->0. It pulses regardless of en.
- Invariant: at most one an bit is low at any time, and never two consecutive digits without an intervening BLANK phase when BLANK_CYCLES >= 1.

Optional Feature:
- Macro: SSEG_LZ_BLANK_EN.
- Enabled: leading-zero suppression. Digit i in 3..1 is blanked when its pattern equals SEG_ZERO (8'hC0) and every higher digit is also blanked. Digit 0 is never suppressed.
  - Evaluated on live inputs at the latch point.
  - Suppression is stored as a 1-bit flag alongside pat_q.
- Disabled: all digits are shown as given; the flag logic is not compiled.

Decomposition:
- Package sseg_pkg:
  - NUM_DIGITS=4
  - SEG_OFF=8'hFF
  - SEG_ZERO=8'hC0
  - AN_OFF=4'b1111
  - typedef seg_t (logic [7:0])
- Sub-module sseg_scan_timer: owns cnt/idx, and outputs idx, latch (cnt==0), show (cnt>=BLANK_CYCLES) and wrap.
- The top level holds pat_q, the force-off logic, the optional LZ logic and the output registers.

Test Plan:
- Bench parameters for all scenarios: DIGIT_CYCLES=8, BLANK_CYCLES=2.
- Reset/basic scan: hold rst_n=0 -> an=1111, sseg=FF. Release, with hex0..3 = F9,A4,B0,99 -> pins show F9 on an=1110 for 6 cycles, then 2 cycles of an=1111/FF, then A4 on 1101, B0 on 1011, 99 on 0111. frame_tick pulses once every 32 cycles.
- Mid-slot change: change hex1 from A4 to 92 during digit-1 SHOW -> current slot still shows A4; the next digit-1 slot shows 92.
- Enable/mask: en=0 for one full frame -> an stays 1111 and frame_tick still pulses. blank_mask=0100 -> digit 2 slot stays dark, other digits are normal.
- Async reset mid-slot: assert rst_n=0 at cnt=5 of digit 2 -> an=1111 and sseg=FF with no clock edge. After release, the scan restarts at digit 0.
- SSEG_LZ_BLANK_EN:
  - hex3..0 = C0,C0,F9,C0 -> digits 3,2 dark; digits 1,0 show F9,C0.
  - hex3..0 = C0,C0,C0,C0 -> only digit 0 lit.
  - Without the macro, all four digits show C0.

Source files
------------

// File: rtl/sseg_pkg.sv
// Shared constants and types for the multiplexed 7-segment display driver.
// Segment patterns are active-low: bit7 = dp, bits6:0 = g..a.
package sseg_pkg;

    localparam int          NUM_DIGITS = 4;
    localparam logic [7:0]  SEG_OFF    = 8'hFF;
    localparam logic [7:0]  SEG_ZERO   = 8'hC0;
    localparam logic [3:0]  AN_OFF     = 4'b1111;

    typedef logic [7:0] seg_t;

    // Active-low one-cold digit enable for the given digit index.
    function automatic logic [3:0] an_for(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/sseg_scan_timer.sv
// Slot timer for the display scan: counts cycles within a digit slot and
// steps the active digit index at the end of each slot.
module sseg_scan_timer
    import sseg_pkg::*;
#(
    parameter int DIGIT_CYCLES = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [1:0] idx,
    output logic       latch,
    output logic       show,
    output logic       wrap
);

    localparam int             CW        = $clog2(DIGIT_CYCLES);
    localparam logic [CW-1:0]  CNT_LAST  = CW'(DIGIT_CYCLES - 1);

    logic [CW-1:0] cnt;
    logic          slot_end;

    assign slot_end = (cnt == CNT_LAST);
    assign latch    = (cnt == '0);
    assign wrap     = slot_end && (idx == 2'd3);

    // Without a blanking interval the whole slot is visible; this avoids an
    // always-true compare against zero.
    generate
        if (BLANK_CYCLES == 0) begin : g_no_blank
            assign show = 1'b1;
        end else begin : g_blank
            localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYCLES);
            assign show = (cnt >= CNT_BLANK);
        end
    endgenerate

    // Slot counter and digit index; index wraps 3->0 naturally in 2 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            idx <= 2'd0;
        end else if (slot_end) begin
            cnt <= '0;
            idx <= idx + 2'd1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/sseg_scan_mux.sv
// Time-multiplexes four active-low 7-segment patterns onto a shared segment
// bus with per-slot blanking against ghosting, per-digit masking and a frame
// strobe. Optional leading-zero suppression is built when SSEG_LZ_BLANK_EN
// is defined.
module sseg_scan_mux
    import sseg_pkg::*;
#(
    parameter int DIGIT_CYCLES = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [3:0] blank_mask,
    input  logic [7:0] hex3,
    input  logic [7:0] hex2,
    input  logic [7:0] hex1,
    input  logic [7:0] hex0,
    output logic [3:0] an,
    output logic [7:0] sseg,
    output logic       frame_tick
);

    logic [1:0] idx;
    logic       latch;
    logic       show;
    logic       wrap;

    sseg_scan_timer #(
        .DIGIT_CYCLES (DIGIT_CYCLES),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .idx   (idx),
        .latch (latch),
        .show  (show),
        .wrap  (wrap)
    );

    logic [NUM_DIGITS-1:0][7:0] hex_bus;
    seg_t                       live_pat;
    seg_t                       pat_q;
    seg_t                       cur_pat;
    logic                       cur_sup;
    logic                       show_on;

    assign hex_bus  = {hex3, hex2, hex1, hex0};
    assign live_pat = hex_bus[idx];
    // On the latch cycle the register is still loading, so use the live
    // pattern; this matters when the slot has no blanking interval.
    assign cur_pat  = latch ? live_pat : pat_q;

    // Capture the active digit's pattern once at the start of its slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pat_q <= SEG_OFF;
        end else if (latch) begin
            pat_q <= live_pat;
        end
    end

`ifdef SSEG_LZ_BLANK_EN
    logic [NUM_DIGITS-1:0] is_zero;
    logic                  lz_live;
    logic                  lz_q;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_zero
            assign is_zero[gi] = (hex_bus[gi] == SEG_ZERO);
        end
    endgenerate

    // Digit is a leading zero if it and every higher digit read zero;
    // digit 0 always stays visible.
    always_comb begin
        lz_live = (idx != 2'd0);
        for (int i = 1; i < NUM_DIGITS; i++) begin
            if ((2'(i) >= idx) && !is_zero[i]) begin
                lz_live = 1'b0;
            end
        end
    end

    // Suppression flag travels with the latched pattern for the whole slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lz_q <= 1'b0;
        end else if (latch) begin
            lz_q <= lz_live;
        end
    end

    assign cur_sup = latch ? lz_live : lz_q;
`else
    assign cur_sup = 1'b0;
`endif

    assign show_on = show && en && !blank_mask[idx] && !cur_sup;

    // Registered pin drivers and frame strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an         <= AN_OFF;
            sseg       <= SEG_OFF;
            frame_tick <= 1'b0;
        end else begin
            an         <= show_on ? an_for(idx) : AN_OFF;
            sseg       <= show_on ? cur_pat : SEG_OFF;
            frame_tick <= wrap;
        end
    end

endmodule

// File: tb/tb_sseg_scan_mux.sv
// Self-checking bench for sseg_scan_mux with DIGIT_CYCLES=8, BLANK_CYCLES=2.
// Honours SSEG_LZ_BLANK_EN for the leading-zero expectations.
module tb_sseg_scan_mux;

    localparam int DC = 8;
    localparam int BC = 2;
    localparam int FRAME = 4 * DC;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b1;
    logic [3:0] blank_mask = 4'b0000;
    logic [7:0] hex_in [4];
    logic [3:0] an;
    logic [7:0] sseg;
    logic       frame_tick;

    always #5 clk = ~clk;

    sseg_scan_mux #(
        .DIGIT_CYCLES (DC),
        .BLANK_CYCLES (BC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .blank_mask (blank_mask),
        .hex3       (hex_in[3]),
        .hex2       (hex_in[2]),
        .hex1       (hex_in[1]),
        .hex0       (hex_in[0]),
        .an         (an),
        .sseg       (sseg),
        .frame_tick (frame_tick)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state: n = cycles since reset release.
    int         n;
    logic [3:0] exp_an;
    logic [7:0] exp_seg;
    logic       exp_tick;
    logic [7:0] slot_pat;
    logic       slot_sup;
    logic [7:0] seen [4];
    int         ticks;

    typedef struct {
        logic [3:0][7:0] hex;
        logic            en;
        logic [3:0]      mask;
        logic [3:0][7:0] exp;
    } vec_t;

    vec_t tbl [6];

    function automatic logic lz_model(input int d);
`ifdef SSEG_LZ_BLANK_EN
        if (d == 0) return 1'b0;
        for (int j = d; j < 4; j++) begin
            if (hex_in[j] != 8'hC0) return 1'b0;
        end
        return 1'b1;
`else
        return (d < 0);
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic reset_model();
        n        = 0;
        exp_an   = 4'b1111;
        exp_seg  = 8'hFF;
        exp_tick = 1'b0;
    endtask

    // Compare the pins of cycle n, then predict cycle n+1 and advance.
    task automatic step();
        int  c;
        int  d;
        logic on;
        checks++;
        if (an !== exp_an || sseg !== exp_seg || frame_tick !== exp_tick ||
            $countones(~an) > 1) begin
            errors++;
            $display("FAIL cycle n=%0d: an=%b sseg=%h tick=%b, expected an=%b sseg=%h tick=%b",
                     n, an, sseg, frame_tick, exp_an, exp_seg, exp_tick);
        end
        for (int k = 0; k < 4; k++) begin
            if (an[k] === 1'b0) seen[k] = sseg;
        end
        if (frame_tick === 1'b1) ticks++;
        c = n % DC;
        d = (n / DC) % 4;
        if (c == 0) begin
            slot_pat = hex_in[d];
            slot_sup = lz_model(d);
        end
        on       = (c >= BC) && en && !blank_mask[d] && !slot_sup;
        exp_an   = on ? ~(4'b0001 << d) : 4'b1111;
        exp_seg  = on ? slot_pat : 8'hFF;
        exp_tick = (c == DC - 1) && (d == 3);
        n++;
        @(negedge clk);
    endtask

    task automatic set_basic();
        hex_in[0] = 8'hF9;
        hex_in[1] = 8'hA4;
        hex_in[2] = 8'hB0;
        hex_in[3] = 8'h99;
        en         = 1'b1;
        blank_mask = 4'b0000;
    endtask

    initial begin
        set_basic();
        slot_pat = 8'hFF;
        slot_sup = 1'b0;
        ticks    = 0;

        // Table: hex/exp packed index 3..0 written high digit first.
        tbl[0] = '{hex: {8'h99, 8'hB0, 8'hA4, 8'hF9}, en: 1'b1, mask: 4'b0000,
                   exp: {8'h99, 8'hB0, 8'hA4, 8'hF9}};
        tbl[1] = '{hex: {8'h99, 8'hB0, 8'hA4, 8'hF9}, en: 1'b0, mask: 4'b0000,
                   exp: {8'hFF, 8'hFF, 8'hFF, 8'hFF}};
        tbl[2] = '{hex: {8'h99, 8'hB0, 8'hA4, 8'hF9}, en: 1'b1, mask: 4'b0100,
                   exp: {8'h99, 8'hFF, 8'hA4, 8'hF9}};
`ifdef SSEG_LZ_BLANK_EN
        tbl[3] = '{hex: {8'hC0, 8'hC0, 8'hF9, 8'hC0}, en: 1'b1, mask: 4'b0000,
                   exp: {8'hFF, 8'hFF, 8'hF9, 8'hC0}};
        tbl[4] = '{hex: {8'hC0, 8'hC0, 8'hC0, 8'hC0}, en: 1'b1, mask: 4'b0000,
                   exp: {8'hFF, 8'hFF, 8'hFF, 8'hC0}};
`else
        tbl[3] = '{hex: {8'hC0, 8'hC0, 8'hF9, 8'hC0}, en: 1'b1, mask: 4'b0000,
                   exp: {8'hC0, 8'hC0, 8'hF9, 8'hC0}};
        tbl[4] = '{hex: {8'hC0, 8'hC0, 8'hC0, 8'hC0}, en: 1'b1, mask: 4'b0000,
                   exp: {8'hC0, 8'hC0, 8'hC0, 8'hC0}};
`endif
        tbl[5] = '{hex: {8'h82, 8'hC0, 8'hC0, 8'h88}, en: 1'b1, mask: 4'b1001,
                   exp: {8'hFF, 8'hC0, 8'hC0, 8'hFF}};

        // Reset state while held.
        repeat (2) @(negedge clk);
        check("reset_an", 32'(an), 32'(4'b1111));
        check("reset_sseg", 32'(sseg), 32'(8'hFF));
        check("reset_tick", 32'(frame_tick), 32'(1'b0));
        rst_n = 1'b1;
        reset_model();

        // Basic scan timing: digit 0 lit on pins from cycle 3.
        repeat (3) step();
        check("first_show_an", 32'(an), 32'(4'b1110));
        check("first_show_sseg", 32'(sseg), 32'(8'hF9));

        // Table-driven frames.
        for (int e = 0; e < 6; e++) begin
            for (int i = 0; i < 4; i++) hex_in[i] = tbl[e].hex[i];
            en         = tbl[e].en;
            blank_mask = tbl[e].mask;
            repeat (FRAME) step();
            for (int i = 0; i < 4; i++) seen[i] = 8'hFF;
            ticks = 0;
            repeat (FRAME) step();
            for (int i = 0; i < 4; i++) check($sformatf("vec%0d_digit%0d", e, i),
                                              32'(seen[i]), 32'(tbl[e].exp[i]));
            check($sformatf("vec%0d_ticks", e), 32'(ticks), 32'd1);
            $display("vec %0d: en=%b mask=%b seen d3..d0 = %h %h %h %h", e, en, blank_mask,
                     seen[3], seen[2], seen[1], seen[0]);
        end

        // Mid-slot change of digit 1 is deferred to its next slot.
        set_basic();
        repeat (FRAME) step();
        for (int i = 0; i < FRAME && (n % FRAME) != 12; i++) step();
        check("mid_before_an", 32'(an), 32'(4'b1101));
        check("mid_before_sseg", 32'(sseg), 32'(8'hA4));
        hex_in[1] = 8'h92;
        repeat (3) step();
        check("mid_same_slot", 32'(sseg), 32'(8'hA4));
        for (int i = 0; i < FRAME && (n % FRAME) != 12; i++) step();
        check("mid_next_slot", 32'(sseg), 32'(8'h92));
        $display("mid-slot change: digit 1 now shows %h", sseg);

        // Asynchronous reset in the middle of digit 2's slot.
        set_basic();
        for (int i = 0; i < FRAME && (n % FRAME) != 21; i++) step();
        check("pre_reset_an", 32'(an), 32'(4'b1011));
        #1 rst_n = 1'b0;
        #1;
        check("async_reset_an", 32'(an), 32'(4'b1111));
        check("async_reset_sseg", 32'(sseg), 32'(8'hFF));
        @(negedge clk);
        rst_n = 1'b1;
        reset_model();
        repeat (3) step();
        check("restart_an", 32'(an), 32'(4'b1110));
        check("restart_sseg", 32'(sseg), 32'(8'hF9));
        $display("async reset: scan restarted at digit 0");

        // Randomized stimulus against the model.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 7) == 0)
                hex_in[$urandom_range(0, 3)] = ($urandom_range(0, 1) == 0) ? 8'hC0 : 8'($urandom);
            if ($urandom_range(0, 19) == 0) en = ~en;
            if ($urandom_range(0, 19) == 0) blank_mask = 4'($urandom);
            step();
        end
        $display("random phase: 400 cycles compared");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
